// File: rtl/ysyx_25010008_lsu_axi.sv
// Load/store unit bridging a single in-flight access onto AXI-lite read/write channels.
// Handles byte-lane placement, load sign/zero extension and misalignment faults; outputs are registered.
module ysyx_25010008_lsu_axi #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [2:0]          req_size,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {IDLE, AR, R, WR, B, DONE} state_t;

    state_t            state, state_n;
    logic              accept, fault;
    logic              awvalid_n, wvalid_n;
    logic [OFF_W-1:0]  req_off, off_q;
    logic [2:0]        size_q;

    function automatic logic is_fault(input logic [2:0] size, input logic [2:0] a);
        logic f;
        case (size[1:0])
            2'd0:    f = 1'b0;
            2'd1:    f = a[0];
            2'd2:    f = |a[1:0];
            default: f = (|a) || (DATA_W == 32);
        endcase
        if (size == 3'b111) f = 1'b1;
        return f;
    endfunction

    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] raw,
                                                      input logic [2:0] size);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        b = raw[7:0];
        h = raw[15:0];
        w = raw[31:0];
        case (size)
            3'b000:  return DATA_W'(b);
            3'b001:  return DATA_W'(h);
            3'b010:  return DATA_W'(w);
            3'b100:  return DATA_W'(raw[7:0]);
            3'b101:  return DATA_W'(raw[15:0]);
            3'b110:  return DATA_W'(raw[31:0]);
            default: return raw;
        endcase
    endfunction

    function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] s);
        logic [7:0] m;
        case (s)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m[STRB_W-1:0];
    endfunction

    assign req_off = req_addr[OFF_W-1:0];
    assign accept  = req_valid && req_ready;
    assign fault   = is_fault(req_size, req_addr[2:0]);

    always_comb begin
        state_n   = state;
        awvalid_n = awvalid;
        wvalid_n  = wvalid;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (fault) begin
                        state_n = DONE;
                    end else if (req_wen) begin
                        state_n   = WR;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                    end else begin
                        state_n = AR;
                    end
                end
            end
            AR:   if (arready) state_n = R;
            R:    if (rvalid) state_n = DONE;
            WR: begin
                // Address and data channels retire independently; B waits for both.
                if (awready) awvalid_n = 1'b0;
                if (wready)  wvalid_n  = 1'b0;
                if (!awvalid_n && !wvalid_n) state_n = B;
            end
            B:    if (bvalid) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_n;
            req_ready  <= (state_n == IDLE);
            arvalid    <= (state_n == AR);
            rready     <= (state_n == R);
            awvalid    <= awvalid_n;
            wvalid     <= wvalid_n;
            bready     <= (state_n == B);
            resp_valid <= (state_n == DONE);
            if (accept && fault) begin
                resp_rdata <= '0;
                resp_err   <= 1'b1;
            end
            if (state == R && rvalid) begin
                resp_rdata <= extend_load(rdata >> {off_q, 3'b000}, size_q);
                resp_err   <= |rresp;
            end
            if (state == B && bvalid) begin
                resp_rdata <= '0;
                resp_err   <= |bresp;
            end
        end
    end

    // Request payload is captured once at acceptance and held for the whole access.
    always_ff @(posedge clock) begin
        if (accept) begin
            size_q <= req_size;
            off_q  <= req_off;
            araddr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            awaddr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wdata  <= req_wdata << {req_off, 3'b000};
            wstrb  <= size_mask(req_size[1:0]) << req_off;
        end
    end
endmodule

// File: tb/tb_ysyx_25010008_lsu_axi.sv
// Bench for ysyx_25010008_lsu_axi: a 32-bit and a 64-bit instance share one reactive AXI slave,
// with expected results computed from byte-lane arithmetic.
module tb_ysyx_25010008_lsu_axi;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, sel64;
    logic        req_valid, req_wen;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, rdata;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [1:0]  rresp, bresp;

    logic        req_ready32, resp_valid32, resp_err32, arvalid32, rready32, awvalid32, wvalid32, bready32;
    logic [31:0] resp_rdata32, araddr32, awaddr32, wdata32;
    logic [3:0]  wstrb32;
    logic        req_ready64, resp_valid64, resp_err64, arvalid64, rready64, awvalid64, wvalid64, bready64;
    logic [63:0] resp_rdata64, wdata64;
    logic [31:0] araddr64, awaddr64;
    logic [7:0]  wstrb64;

    int n_cmp = 0;
    int n_fail = 0;

    ysyx_25010008_lsu_axi #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid && !sel64), .req_ready(req_ready32), .req_wen(req_wen),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(resp_valid32), .resp_rdata(resp_rdata32), .resp_err(resp_err32),
        .araddr(araddr32), .arvalid(arvalid32), .arready(arready),
        .rdata(rdata[31:0]), .rresp(rresp), .rvalid(rvalid), .rready(rready32),
        .awaddr(awaddr32), .awvalid(awvalid32), .awready(awready),
        .wdata(wdata32), .wstrb(wstrb32), .wvalid(wvalid32), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready32)
    );

    ysyx_25010008_lsu_axi #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid && sel64), .req_ready(req_ready64), .req_wen(req_wen),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid64), .resp_rdata(resp_rdata64), .resp_err(resp_err64),
        .araddr(araddr64), .arvalid(arvalid64), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready64),
        .awaddr(awaddr64), .awvalid(awvalid64), .awready(awready),
        .wdata(wdata64), .wstrb(wstrb64), .wvalid(wvalid64), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready64)
    );

    // Views of whichever instance is currently selected.
    logic        v_req_ready, v_resp_valid, v_resp_err, v_arvalid, v_rready, v_awvalid, v_wvalid, v_bready;
    logic [63:0] v_resp_rdata, v_wdata;
    logic [31:0] v_araddr, v_awaddr;
    logic [7:0]  v_wstrb;
    assign v_req_ready  = sel64 ? req_ready64  : req_ready32;
    assign v_resp_valid = sel64 ? resp_valid64 : resp_valid32;
    assign v_resp_err   = sel64 ? resp_err64   : resp_err32;
    assign v_arvalid    = sel64 ? arvalid64    : arvalid32;
    assign v_rready     = sel64 ? rready64     : rready32;
    assign v_awvalid    = sel64 ? awvalid64    : awvalid32;
    assign v_wvalid     = sel64 ? wvalid64     : wvalid32;
    assign v_bready     = sel64 ? bready64     : bready32;
    assign v_resp_rdata = sel64 ? resp_rdata64 : {32'h0, resp_rdata32};
    assign v_wdata      = sel64 ? wdata64      : {32'h0, wdata32};
    assign v_araddr     = sel64 ? araddr64     : araddr32;
    assign v_awaddr     = sel64 ? awaddr64     : awaddr32;
    assign v_wstrb      = sel64 ? wstrb64      : {4'h0, wstrb32};

    function automatic int nbytes_bus();
        return sel64 ? 8 : 4;
    endfunction

    function automatic logic [63:0] bus_mask();
        return sel64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic bit model_fault(input logic [31:0] addr, input logic [2:0] size);
        int bytes;
        bytes = 1 << size[1:0];
        if (size == 3'b111) return 1'b1;
        if (size == 3'b011 && !sel64) return 1'b1;
        return (addr % bytes) != 0;
    endfunction

    function automatic logic [63:0] model_load(input logic [31:0] addr, input logic [2:0] size,
                                               input logic [63:0] rd);
        int off, bits;
        logic [63:0] v, mask;
        off  = int'(addr % nbytes_bus());
        bits = 8 * (1 << size[1:0]);
        mask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
        v = ((rd & bus_mask()) >> (8 * off)) & mask;
        if (!size[2] && v[bits-1]) v = v | ~mask;
        return v & bus_mask();
    endfunction

    task automatic run_load(input logic [31:0] addr, input logic [2:0] size, input logic [63:0] rd,
                            input logic [1:0] rr, input int ar_wait, input int r_wait, input string name);
        bit fault, exp_err, got, ar_done, r_done, ar_seen;
        logic [63:0] exp_data;
        logic [31:0] exp_addr;
        int exp_lat, n, ar_cnt, r_cnt;
        fault    = model_fault(addr, size);
        exp_data = fault ? 64'h0 : model_load(addr, size, rd);
        exp_err  = fault || (rr != 2'b00);
        exp_lat  = fault ? 1 : 3 + ar_wait + r_wait;
        exp_addr = addr & ~32'(nbytes_bus() - 1);
        @(negedge clock);
        n_cmp++;
        if (v_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s req_ready: got %b want 1", name, v_req_ready);
        end
        req_valid = 1'b1; req_wen = 1'b0; req_size = size; req_addr = addr;
        req_wdata = {$urandom, $urandom};
        @(negedge clock);
        req_valid = 1'b0;
        n = 1; got = 0; ar_done = 0; r_done = 0; ar_seen = 0; ar_cnt = 0; r_cnt = 0;
        while (!got && n <= 40) begin
            if (arready) ar_done = 1;
            if (rvalid) r_done = 1;
            arready = 1'b0; rvalid = 1'b0;
            if (v_resp_valid) begin
                got = 1;
                n_cmp++;
                if (n !== exp_lat) begin
                    n_fail++; $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
                end
                n_cmp++;
                if (v_resp_rdata !== exp_data) begin
                    n_fail++; $display("FAIL %s resp_rdata: got %h want %h", name, v_resp_rdata, exp_data);
                end
                n_cmp++;
                if (v_resp_err !== exp_err) begin
                    n_fail++; $display("FAIL %s resp_err: got %b want %b", name, v_resp_err, exp_err);
                end
                n_cmp++;
                if (ar_seen !== !fault) begin
                    n_fail++; $display("FAIL %s ar_traffic: got %b want %b", name, ar_seen, !fault);
                end
            end else begin
                n_cmp++;
                if (v_arvalid !== (!fault && !ar_done)) begin
                    n_fail++; $display("FAIL %s arvalid: got %b want %b", name, v_arvalid, !fault && !ar_done);
                end
                n_cmp++;
                if (v_rready !== (!fault && ar_done && !r_done)) begin
                    n_fail++; $display("FAIL %s rready: got %b want %b", name, v_rready, !fault && ar_done && !r_done);
                end
                if (v_arvalid) begin
                    ar_seen = 1;
                    n_cmp++;
                    if (v_araddr !== exp_addr) begin
                        n_fail++; $display("FAIL %s araddr: got %h want %h", name, v_araddr, exp_addr);
                    end
                    if (ar_cnt == ar_wait) arready = 1'b1;
                    ar_cnt++;
                end
                if (v_rready) begin
                    if (r_cnt == r_wait) begin
                        rvalid = 1'b1; rdata = rd; rresp = rr;
                    end else begin
                        rdata = {$urandom, $urandom}; rresp = 2'(~rr);
                    end
                    r_cnt++;
                end
                @(negedge clock);
                n++;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL %s timeout: got no resp_valid want one within %0d cycles", name, 40);
        end
        @(negedge clock);
        n_cmp++;
        if (v_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s resp_pulse: got %b want 0", name, v_resp_valid);
        end
        n_cmp++;
        if (v_resp_rdata !== exp_data) begin
            n_fail++; $display("FAIL %s resp_hold: got %h want %h", name, v_resp_rdata, exp_data);
        end
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [2:0] size, input logic [63:0] wd,
                             input logic [1:0] br, input int aw_wait, input int w_wait, input int b_wait,
                             input string name);
        bit fault, exp_err, got, aw_done, w_done, b_done, aw_seen, w_seen;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wstrb;
        logic [31:0] exp_addr;
        int exp_lat, n, aw_cnt, w_cnt, b_cnt, off;
        fault     = model_fault(addr, size);
        off       = int'(addr % nbytes_bus());
        exp_wdata = ((wd & bus_mask()) << (8 * off)) & bus_mask();
        exp_wstrb = 8'((((1 << (1 << size[1:0])) - 1) << off) & ((1 << nbytes_bus()) - 1));
        exp_err   = fault || (br != 2'b00);
        exp_lat   = fault ? 1 : 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait;
        exp_addr  = addr & ~32'(nbytes_bus() - 1);
        @(negedge clock);
        n_cmp++;
        if (v_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s req_ready: got %b want 1", name, v_req_ready);
        end
        req_valid = 1'b1; req_wen = 1'b1; req_size = size; req_addr = addr; req_wdata = wd;
        @(negedge clock);
        req_valid = 1'b0;
        n = 1; got = 0; aw_done = 0; w_done = 0; b_done = 0; aw_seen = 0; w_seen = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        while (!got && n <= 40) begin
            if (awready) aw_done = 1;
            if (wready) w_done = 1;
            if (bvalid) b_done = 1;
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            if (v_resp_valid) begin
                got = 1;
                n_cmp++;
                if (n !== exp_lat) begin
                    n_fail++; $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
                end
                n_cmp++;
                if (v_resp_err !== exp_err) begin
                    n_fail++; $display("FAIL %s resp_err: got %b want %b", name, v_resp_err, exp_err);
                end
                n_cmp++;
                if ((aw_seen || w_seen) !== !fault) begin
                    n_fail++; $display("FAIL %s w_traffic: got %b want %b", name, aw_seen || w_seen, !fault);
                end
            end else begin
                n_cmp++;
                if (v_awvalid !== (!fault && !aw_done)) begin
                    n_fail++; $display("FAIL %s awvalid: got %b want %b", name, v_awvalid, !fault && !aw_done);
                end
                n_cmp++;
                if (v_wvalid !== (!fault && !w_done)) begin
                    n_fail++; $display("FAIL %s wvalid: got %b want %b", name, v_wvalid, !fault && !w_done);
                end
                n_cmp++;
                if (v_bready !== (!fault && aw_done && w_done && !b_done)) begin
                    n_fail++; $display("FAIL %s bready: got %b want %b", name, v_bready, !fault && aw_done && w_done && !b_done);
                end
                if (v_awvalid) begin
                    aw_seen = 1;
                    n_cmp++;
                    if (v_awaddr !== exp_addr) begin
                        n_fail++; $display("FAIL %s awaddr: got %h want %h", name, v_awaddr, exp_addr);
                    end
                    if (aw_cnt == aw_wait) awready = 1'b1;
                    aw_cnt++;
                end
                if (v_wvalid) begin
                    w_seen = 1;
                    n_cmp++;
                    if (v_wdata !== exp_wdata) begin
                        n_fail++; $display("FAIL %s wdata: got %h want %h", name, v_wdata, exp_wdata);
                    end
                    n_cmp++;
                    if (v_wstrb !== exp_wstrb) begin
                        n_fail++; $display("FAIL %s wstrb: got %b want %b", name, v_wstrb, exp_wstrb);
                    end
                    if (w_cnt == w_wait) wready = 1'b1;
                    w_cnt++;
                end
                if (v_bready) begin
                    if (b_cnt == b_wait) begin
                        bvalid = 1'b1; bresp = br;
                    end else begin
                        bresp = 2'(~br);
                    end
                    b_cnt++;
                end
                @(negedge clock);
                n++;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL %s timeout: got no resp_valid want one within %0d cycles", name, 40);
        end
        @(negedge clock);
        n_cmp++;
        if (v_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s resp_pulse: got %b want 0", name, v_resp_valid);
        end
        n_cmp++;
        if (v_resp_err !== exp_err) begin
            n_fail++; $display("FAIL %s err_hold: got %b want %b", name, v_resp_err, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({v_req_ready, v_arvalid, v_rready, v_awvalid, v_wvalid, v_bready} !== 6'b0) begin
            n_fail++; $display("FAIL reset_handshakes: got %b want 000000",
                               {v_req_ready, v_arvalid, v_rready, v_awvalid, v_wvalid, v_bready});
        end
        n_cmp++;
        if ({v_resp_valid, v_resp_err} !== 2'b00) begin
            n_fail++; $display("FAIL reset_resp: got %b want 00", {v_resp_valid, v_resp_err});
        end
        n_cmp++;
        if (v_resp_rdata !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 0", v_resp_rdata);
        end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (v_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b want 1", v_req_ready);
        end
    endtask

    task automatic test_directed32();
        run_load(32'h8000_0003, 3'b000, 64'h8012_3456, 2'b00, 0, 0, "lb_sign");
        run_store(32'h8000_0002, 3'b001, 64'h0000_ABCD, 2'b00, 2, 0, 0, "sh_aw_delay");
        run_load(32'h8000_0001, 3'b010, 64'hDEAD_BEEF, 2'b00, 0, 0, "lw_misaligned");
        run_load(32'h8000_0002, 3'b101, 64'h1234_5678, 2'b10, 0, 0, "lhu_rresp");
        run_load(32'h8000_0008, 3'b011, 64'h1111_2222, 2'b00, 0, 0, "ld_on_32bit");
        run_store(32'h8000_0004, 3'b111, 64'h5555_AAAA, 2'b00, 0, 0, 0, "size7_store");
        run_store(32'h8000_0000, 3'b010, 64'hCAFE_F00D, 2'b01, 0, 2, 1, "sw_w_delay_berr");
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        req_valid = 1'b1; req_wen = 1'b1; req_size = 3'b010; req_addr = 32'h8000_0010;
        req_wdata = 64'h0BAD_CAFE;
        awready = 1'b0; wready = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        n_cmp++;
        if (v_awvalid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_in_wr: got awvalid %b want 1", v_awvalid);
        end
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({v_awvalid, v_wvalid, v_resp_valid} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_drop: got %b want 000", {v_awvalid, v_wvalid, v_resp_valid});
        end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (v_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_ready: got %b want 1", v_req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({v_resp_valid, v_awvalid, v_wvalid} !== 3'b000) begin
                n_fail++; $display("FAIL rstmid_quiet: got %b want 000", {v_resp_valid, v_awvalid, v_wvalid});
            end
            @(negedge clock);
        end
    endtask

    task automatic test_random(input int count, input string tag);
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  err;
        for (int i = 0; i < count; i++) begin
            addr = 32'h8000_0000 | ($urandom & 32'h0000_00FF);
            err  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 1) == 0) begin
                size = 3'($urandom_range(0, 7));
                run_load(addr, size, {$urandom, $urandom}, err,
                         $urandom_range(0, 2), $urandom_range(0, 2), tag);
            end else begin
                size = 3'($urandom_range(0, 4));
                if (size == 3'd4) size = 3'b111;
                run_store(addr, size, {$urandom, $urandom}, err,
                          $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), tag);
            end
        end
    endtask

    task automatic test_dw64();
        sel64 = 1'b1;
        run_load(32'h8000_0008, 3'b011, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0, "ld64");
        run_load(32'h8000_0004, 3'b010, 64'hDEAD_BEEF_0000_0000, 2'b00, 1, 0, "lw64_hi");
        run_load(32'h8000_0004, 3'b110, 64'hDEAD_BEEF_0000_0000, 2'b00, 0, 1, "lwu64_hi");
        run_store(32'h8000_0006, 3'b001, 64'h0000_0000_0000_BEEF, 2'b00, 1, 1, 0, "sh64");
        run_load(32'h8000_000C, 3'b011, 64'h1, 2'b00, 0, 0, "ld64_misaligned");
        test_random(30, "rand64");
        sel64 = 1'b0;
    endtask

    initial begin
        sel64 = 1'b0; reset = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_size = 3'b0; req_addr = 32'h0; req_wdata = 64'h0;
        arready = 1'b0; rvalid = 1'b0; rdata = 64'h0; rresp = 2'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b0;
        test_reset();
        test_directed32();
        test_reset_mid();
        test_random(60, "rand32");
        test_dw64();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
